// File: rtl/fc_input_feeder_if.sv
// fc_input_feeder_if: upstream write port and FC-side beat port of the FC input feeder.
interface fc_input_feeder_if #(
   parameter int INPUT_IDX_WIDTH = 10
);
   logic                       wr_en;
   logic [INPUT_IDX_WIDTH-1:0] wr_addr;
   logic [31:0]                wr_data;
   logic                       wr_commit;
   logic                       wr_rdy;
   logic                       fc_in_rdy;
   logic [31:0]                fc_input;
   logic [INPUT_IDX_WIDTH-1:0] fc_input_idx;
   logic                       frame_done;
   logic                       overflow;
   modport master (
      output wr_en, wr_addr, wr_data, wr_commit, fc_in_rdy,
      input  wr_rdy, fc_input, fc_input_idx, frame_done, overflow
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, wr_commit, fc_in_rdy,
      output wr_rdy, fc_input, fc_input_idx, frame_done, overflow
   );
endinterface

// File: rtl/fc_input_feeder.sv
// fc_input_feeder: double-buffered frame staging ahead of the FC layer.
// Define FC_FEEDER_RELU_EN to apply ReLU to each word at readout.
module fc_input_feeder #(
   parameter int INPUT_WIDTH     = 1024,
   parameter int INPUT_IDX_WIDTH = 10
) (
   input logic              clk,
   input logic              rst_n,
   fc_input_feeder_if.slave io
);
   localparam logic [INPUT_IDX_WIDTH-1:0] LAST = INPUT_IDX_WIDTH'(INPUT_WIDTH - 1);
   typedef enum logic [1:0] {IDLE, STREAM, PARK} state_t;
   state_t                     r_state;
   logic [31:0]                r_mem0 [INPUT_WIDTH];
   logic [31:0]                r_mem1 [INPUT_WIDTH];
   logic [1:0]                 r_full;
   logic                       r_wr_bank;
   logic                       r_rd_bank;
   logic                       r_wr_rdy;
   logic                       r_overflow;
   logic                       r_frame_done;
   logic [INPUT_IDX_WIDTH-1:0] r_idx;
   logic [31:0]                r_fc_input;
   logic                       w_wr;
   logic                       w_commit;
   logic                       w_next_bank;
   logic                       w_start;
   logic                       w_adv;
   logic                       w_release;
   logic                       w_rd_bank;
   logic [INPUT_IDX_WIDTH-1:0] w_rd_idx;
   logic [1:0]                 w_full_nxt;
   logic [31:0]                w_word;
   logic [31:0]                w_out;
   // The write bank is never FULL while r_wr_rdy=1, so commit and release always hit different banks.
   always_comb begin
      w_wr        = io.wr_en & r_wr_rdy;
      w_commit    = io.wr_commit & r_wr_rdy;
      w_next_bank = r_full[~r_rd_bank] ? ~r_rd_bank : r_rd_bank;
      w_start     = (r_state != STREAM) & io.fc_in_rdy & r_full[w_next_bank];
      w_adv       = (r_state == STREAM) & io.fc_in_rdy;
      w_rd_idx    = w_start ? '0 : r_idx + 1'b1;
      w_rd_bank   = w_start ? w_next_bank : r_rd_bank;
      w_release   = w_adv & (w_rd_idx == LAST);
      w_full_nxt  = (r_full | ({1'b0, w_commit} << r_wr_bank)) & ~({1'b0, w_release} << r_rd_bank);
      w_word      = w_rd_bank ? r_mem1[w_rd_idx] : r_mem0[w_rd_idx];
`ifdef FC_FEEDER_RELU_EN
      w_out       = w_word[31] ? 32'h0 : w_word;
`else
      w_out       = w_word;
`endif
   end
   always_ff @(posedge clk) begin
      if (w_wr && !r_wr_bank) r_mem0[io.wr_addr] <= io.wr_data;
      if (w_wr && r_wr_bank) r_mem1[io.wr_addr] <= io.wr_data;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_full       <= '0;
         r_wr_bank    <= 1'b0;
         r_rd_bank    <= 1'b0;
         r_wr_rdy     <= 1'b1;
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
         r_idx        <= LAST;
         r_fc_input   <= '0;
      end else begin
         r_full       <= w_full_nxt;
         r_overflow   <= r_overflow | ((io.wr_en | io.wr_commit) & ~r_wr_rdy);
         r_frame_done <= w_release;
         if (w_commit) begin
            if (w_full_nxt[~r_wr_bank]) r_wr_rdy <= 1'b0;
            else r_wr_bank <= ~r_wr_bank;
         end else if (!r_wr_rdy && w_release) begin
            r_wr_rdy  <= 1'b1;
            r_wr_bank <= r_rd_bank;
         end
         if (w_start || w_adv) begin
            r_idx      <= w_rd_idx;
            r_rd_bank  <= w_rd_bank;
            r_fc_input <= w_out;
         end
         r_state <= w_release ? PARK : w_start ? STREAM : (r_state == PARK) ? IDLE : r_state;
      end
   end
   assign io.wr_rdy      = r_wr_rdy;
   assign io.fc_input    = r_fc_input;
   assign io.fc_input_idx = r_idx;
   assign io.frame_done  = r_frame_done;
   assign io.overflow    = r_overflow;
endmodule

// File: tb/tb_fc_input_feeder.sv
// tb_fc_input_feeder: directed bench for fc_input_feeder (1024-word frames).
module tb_fc_input_feeder;
   localparam int W = 1024;
   logic clk;
   logic rst_n;
   int   n_chk = 0;
   int   n_bad = 0;
   logic [31:0] exp_mem [4][W];
   fc_input_feeder_if #(.INPUT_IDX_WIDTH(10)) bus ();
   fc_input_feeder #(.INPUT_WIDTH(W), .INPUT_IDX_WIDTH(10)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .io   (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [31:0] f_out(input logic [31:0] w);
`ifdef FC_FEEDER_RELU_EN
      return w[31] ? 32'h0 : w;
`else
      return w;
`endif
   endfunction
   task automatic wr(input logic en, input int a, input logic [31:0] d, input logic c);
      bus.wr_en = en;
      bus.wr_addr = 10'(a);
      bus.wr_data = d;
      bus.wr_commit = c;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.wr_commit = 1'b0;
   endtask
   task automatic run_frame(input int f, input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         chk("beat_idx", 32'(bus.fc_input_idx), 32'(k));
         chk("beat_data", bus.fc_input, f_out(exp_mem[f][k]));
         chk("beat_done", 32'(bus.frame_done), 32'(k == W - 1));
      end
   endtask
   task automatic chk_reset();
      chk("rst_idx", 32'(bus.fc_input_idx), 32'(W - 1));
      chk("rst_data", bus.fc_input, 32'h0);
      chk("rst_done", 32'(bus.frame_done), 32'h0);
      chk("rst_ovf", 32'(bus.overflow), 32'h0);
      chk("rst_wr_rdy", 32'(bus.wr_rdy), 32'h1);
   endtask
   initial begin
      bus.wr_en = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_commit = 1'b0;
      bus.fc_in_rdy = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < W; k++) begin
         exp_mem[0][k] = 32'(k) << 16;
         exp_mem[1][k] = 32'h0A00_0000 | 32'(k);
         exp_mem[2][k] = (k < 512) ? (32'h0B00_0000 | 32'(k)) : exp_mem[0][k];
         exp_mem[3][k] = (k < 10) ? (32'h0C00_0000 | 32'(k)) : exp_mem[1][k];
      end
      exp_mem[2][W-1] = 32'h0005_0000;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset();
      rst_n = 1'b1;
      // frame 0 into bank 0, commit on its own cycle
      for (int k = 0; k < W; k++) wr(1'b1, k, exp_mem[0][k], 1'b0);
      wr(1'b0, 0, 32'h0, 1'b1);
      chk("lat0_idx", 32'(bus.fc_input_idx), 32'(W - 1));
      run_frame(0, W);
      @(posedge clk);
      #1;
      chk("idle_idx", 32'(bus.fc_input_idx), 32'(W - 1));
      chk("idle_done", 32'(bus.frame_done), 32'h0);
      // frame A, last word written together with commit
      for (int k = 0; k < W - 1; k++) wr(1'b1, k, exp_mem[1][k], 1'b0);
      wr(1'b1, W - 1, exp_mem[1][W-1], 1'b1);
      chk("latA_idx", 32'(bus.fc_input_idx), 32'(W - 1));
      chk("latA_wr_rdy", 32'(bus.wr_rdy), 32'h1);
      fork
         begin
            run_frame(1, W);
            chk("freed_wr_rdy", 32'(bus.wr_rdy), 32'h1);
            bus.fc_in_rdy = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(posedge clk);
               #1;
               chk("hold_idx", 32'(bus.fc_input_idx), 32'(W - 1));
               chk("hold_data", bus.fc_input, f_out(exp_mem[1][W-1]));
               chk("hold_done", 32'(bus.frame_done), 32'h0);
            end
            bus.fc_in_rdy = 1'b1;
         end
         begin
            for (int k = 0; k < 512; k++) wr(1'b1, k, exp_mem[2][k], 1'b0);
            wr(1'b1, W - 1, 32'h0005_0000, 1'b1);
            chk("both_full_wr_rdy", 32'(bus.wr_rdy), 32'h0);
            chk("pre_ovf", 32'(bus.overflow), 32'h0);
            wr(1'b1, 5, 32'hDEAD_BEEF, 1'b0);
            chk("ovf_set", 32'(bus.overflow), 32'h1);
            chk("ovf_wr_rdy", 32'(bus.wr_rdy), 32'h0);
         end
      join
      run_frame(2, W);
      chk("ovf_sticky", 32'(bus.overflow), 32'h1);
      // frame C over stale bank, reset mid-frame at idx 500
      for (int k = 0; k < 9; k++) wr(1'b1, k, exp_mem[3][k], 1'b0);
      wr(1'b1, 9, exp_mem[3][9], 1'b1);
      run_frame(3, 501);
      rst_n = 1'b0;
      #1;
      chk_reset();
      @(posedge clk);
      #1;
      chk_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_idx", 32'(bus.fc_input_idx), 32'(W - 1));
      end
      // negative word through readout
      wr(1'b1, 0, 32'hFFFF_0000, 1'b0);
      wr(1'b1, 1, 32'h0001_8000, 1'b1);
      chk("latR_idx", 32'(bus.fc_input_idx), 32'(W - 1));
      @(posedge clk);
      #1;
      chk("relu_idx", 32'(bus.fc_input_idx), 32'h0);
`ifdef FC_FEEDER_RELU_EN
      chk("relu_data", bus.fc_input, 32'h0000_0000);
`else
      chk("relu_data", bus.fc_input, 32'hFFFF_0000);
`endif
      @(posedge clk);
      #1;
      chk("pos_idx", 32'(bus.fc_input_idx), 32'h1);
      chk("pos_data", bus.fc_input, 32'h0001_8000);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
